race_stimulus_gen: RTL

//  Launcher side of the first-signal race: drives a/b/c with programmed per-channel delays from one start pulse.

---
 rtl/race_stim_pkg.sv | 62 ++++++
 rtl/race_stimulus_gen_if.sv | 39 +++
 rtl/race_stim_chan.sv | 45 ++++
 rtl/race_stimulus_gen.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/race_stim_pkg.sv
// Shared types, widths and helpers for the race stimulus generator.
// Purpose : FSM state enum, channel index constants, delay/hold widths and
//           helpers that reduce the three channel delays to a min mask / max delay.
// Ports   : none (package).
package race_stim_pkg;

  localparam int unsigned DLY_W  = 8;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned NUM_CH = 3;

  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_C = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Mask of enabled channels whose delay equals the smallest enabled delay.
  function automatic logic [NUM_CH-1:0] min_mask(input logic [NUM_CH-1:0] en,
                                                 input logic [DLY_W-1:0]  dly_a,
                                                 input logic [DLY_W-1:0]  dly_b,
                                                 input logic [DLY_W-1:0]  dly_c);
    logic [DLY_W-1:0]  d [NUM_CH];
    logic [DLY_W-1:0]  mn;
    logic [NUM_CH-1:0] m;
    d[CH_A] = dly_a;
    d[CH_B] = dly_b;
    d[CH_C] = dly_c;
    mn = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en[i] && (d[i] < mn)) mn = d[i];
    end
    m = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      m[i] = en[i] && (d[i] == mn);
    end
    return m;
  endfunction

  // Largest delay among enabled channels (0 when none enabled).
  function automatic logic [DLY_W-1:0] max_dly(input logic [NUM_CH-1:0] en,
                                               input logic [DLY_W-1:0]  dly_a,
                                               input logic [DLY_W-1:0]  dly_b,
                                               input logic [DLY_W-1:0]  dly_c);
    logic [DLY_W-1:0] d [NUM_CH];
    logic [DLY_W-1:0] mx;
    d[CH_A] = dly_a;
    d[CH_B] = dly_b;
    d[CH_C] = dly_c;
    mx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (en[i] && (d[i] > mx)) mx = d[i];
    end
    return mx;
  endfunction

endpackage

// File: rtl/race_stimulus_gen_if.sv
// Sequencer <-> race stimulus generator bundle.
// Purpose : carries the launch request/config and the race outputs.
// Signals : start, en[2:0], dly_a/b/c, hold_cyc (sequencer -> generator);
//           det_clr, a, b, c, busy, done, exp_y[2:0] (generator -> detector/sequencer).
//           With RACE_STIM_CHECK_EN: y_obs[2:0] in, pass/fail out.
interface race_stimulus_gen_if;

  logic                               start;
  logic [2:0]                         en;
  logic [race_stim_pkg::DLY_W-1:0]    dly_a;
  logic [race_stim_pkg::DLY_W-1:0]    dly_b;
  logic [race_stim_pkg::DLY_W-1:0]    dly_c;
  logic [race_stim_pkg::HOLD_W-1:0]   hold_cyc;
  logic                               det_clr;
  logic                               a;
  logic                               b;
  logic                               c;
  logic                               busy;
  logic                               done;
  logic [2:0]                         exp_y;
`ifdef RACE_STIM_CHECK_EN
  logic [2:0]                         y_obs;
  logic                               pass;
  logic                               fail;
`endif

`ifdef RACE_STIM_CHECK_EN
  modport master (output start, en, dly_a, dly_b, dly_c, hold_cyc, y_obs,
                  input  det_clr, a, b, c, busy, done, exp_y, pass, fail);
  modport slave  (input  start, en, dly_a, dly_b, dly_c, hold_cyc, y_obs,
                  output det_clr, a, b, c, busy, done, exp_y, pass, fail);
`else
  modport master (output start, en, dly_a, dly_b, dly_c, hold_cyc,
                  input  det_clr, a, b, c, busy, done, exp_y);
  modport slave  (input  start, en, dly_a, dly_b, dly_c, hold_cyc,
                  output det_clr, a, b, c, busy, done, exp_y);
`endif

endinterface

// File: rtl/race_stim_chan.sv
// One race channel.
// Purpose : latches its enable/delay at launch and drives a registered output
//           that rises once the race counter reaches its delay and stays up
//           through HOLD.
// Ports   : clk, rst (async, active-high); i_load latch strobe; i_en/i_dly config;
//           i_run_nxt/i_hold_nxt/i_cnt_nxt next-cycle FSM view; o_out channel level.
module race_stim_chan
  import race_stim_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [DLY_W-1:0] i_dly,
  input  logic             i_run_nxt,
  input  logic             i_hold_nxt,
  input  logic [DLY_W-1:0] i_cnt_nxt,
  output logic             o_out
);

  logic             r_en;
  logic [DLY_W-1:0] r_dly;
  logic             r_out;

  // Config latch, only on launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en  <= 1'b0;
      r_dly <= '0;
    end else if (i_load) begin
      r_en  <= i_en;
      r_dly <= i_dly;
    end
  end

  // Output is computed from the next-cycle counter so the level lines up with
  // the RUN cycle whose count equals the delay; counter is monotonic so >= holds it up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= 1'b0;
    else     r_out <= r_en & ((i_run_nxt & (i_cnt_nxt >= r_dly)) | i_hold_nxt);
  end

  assign o_out = r_out;

endmodule

// File: rtl/race_stimulus_gen.sv
// Race stimulus generator (launcher side of the first-signal race).
// Purpose : on start, clears the detector, runs a/b/c up at their programmed
//           delays, holds them, then signals done and returns to idle.
//           exp_y publishes which enabled channels share the minimum delay.
// Ports   : clk, rst (async, active-high); bus (race_stimulus_gen_if.slave).
// Option  : RACE_STIM_CHECK_EN adds y_obs compare with pass/fail pulses in DONE.
module race_stimulus_gen
  import race_stim_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  race_stimulus_gen_if.slave  bus
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DLY_W-1:0]  r_cnt;
  logic [DLY_W-1:0]  w_cnt_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_load;

  logic [2:0]        r_en;
  logic [DLY_W-1:0]  r_max_dly;
  logic [HOLD_W-1:0] r_hold_len;
  logic [2:0]        r_exp_y;
  logic              r_det_clr;
  logic              r_busy;
  logic              r_done;
  logic [2:0]        w_ch_out;
  logic              w_run_nxt;
  logic              w_hold_nxt;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_hold_cnt_nxt = r_hold_cnt;
    w_load         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load      = 1'b1;
          w_state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        w_cnt_nxt      = '0;
        w_hold_cnt_nxt = '0;
        w_state_nxt    = (r_en == 3'b000) ? DONE : RUN;
      end
      RUN: begin
        // Stop on the compare so the counter never wraps.
        if (r_cnt == r_max_dly) w_state_nxt = HOLD;
        else                    w_cnt_nxt   = r_cnt + DLY_W'(1);
      end
      HOLD: begin
        if (r_hold_cnt == (r_hold_len - HOLD_W'(1))) w_state_nxt    = DONE;
        else                                         w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Launch-time config latch; exp_y stays stable until the next launch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en       <= '0;
      r_max_dly  <= '0;
      r_hold_len <= HOLD_W'(1);
      r_exp_y    <= '0;
    end else if (w_load) begin
      r_en       <= bus.en;
      r_max_dly  <= max_dly(bus.en, bus.dly_a, bus.dly_b, bus.dly_c);
      r_hold_len <= (bus.hold_cyc == '0) ? HOLD_W'(1) : bus.hold_cyc;
      r_exp_y    <= min_mask(bus.en, bus.dly_a, bus.dly_b, bus.dly_c);
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_det_clr <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_det_clr <= (w_state_nxt == CLEAR);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == DONE);
    end
  end

  assign w_run_nxt  = (w_state_nxt == RUN);
  assign w_hold_nxt = (w_state_nxt == HOLD);

  race_stim_chan u_chan_a (
    .clk(clk), .rst(rst), .i_load(w_load), .i_en(bus.en[CH_A]), .i_dly(bus.dly_a),
    .i_run_nxt(w_run_nxt), .i_hold_nxt(w_hold_nxt), .i_cnt_nxt(w_cnt_nxt),
    .o_out(w_ch_out[CH_A])
  );

  race_stim_chan u_chan_b (
    .clk(clk), .rst(rst), .i_load(w_load), .i_en(bus.en[CH_B]), .i_dly(bus.dly_b),
    .i_run_nxt(w_run_nxt), .i_hold_nxt(w_hold_nxt), .i_cnt_nxt(w_cnt_nxt),
    .o_out(w_ch_out[CH_B])
  );

  race_stim_chan u_chan_c (
    .clk(clk), .rst(rst), .i_load(w_load), .i_en(bus.en[CH_C]), .i_dly(bus.dly_c),
    .i_run_nxt(w_run_nxt), .i_hold_nxt(w_hold_nxt), .i_cnt_nxt(w_cnt_nxt),
    .o_out(w_ch_out[CH_C])
  );

  assign bus.det_clr = r_det_clr;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.exp_y   = r_exp_y;
  assign bus.a       = w_ch_out[CH_A];
  assign bus.b       = w_ch_out[CH_B];
  assign bus.c       = w_ch_out[CH_C];

`ifdef RACE_STIM_CHECK_EN
  logic r_pass;
  logic r_fail;

  // y_obs is compared on the edge entering DONE, i.e. as seen in the last
  // HOLD cycle (or in CLEAR when no channel is enabled).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_pass <= (w_state_nxt == DONE) && (bus.y_obs == r_exp_y);
      r_fail <= (w_state_nxt == DONE) && (bus.y_obs != r_exp_y);
    end
  end

  assign bus.pass = r_pass;
  assign bus.fail = r_fail;
`endif

endmodule
